id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-select and forwarding logic for the pipelined RISC-V core.
- Captures decoded instruction fields from the decode stage each cycle.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Drives the ALU operand, opcode and funct inputs directly.
- Detects load-use hazards and inserts a bubble while signalling decode to hold.

Parameters:
- XLEN, 32, datapath width
- REGW, 5, register index width

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode stage holds a valid instruction
- id_pc  in  XLEN  PC of decoded instruction
- id_rs1_data / id_rs2_data  in  XLEN  register file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1 / id_rs2 / id_rd  in  REGW  register indices
- id_opcode  in  7  opcode
- id_funct3  in  3  funct3
- id_funct7  in  7  funct7
- id_reg_write / id_mem_read / id_mem_write  in  1  control bits
- stall  in  1  downstream hold request
- flush  in  1  squash request from branch/jump resolution
- exmem_reg_write  in  1  EX/MEM writes back
- exmem_rd  in  REGW  EX/MEM destination
- exmem_result  in  XLEN  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB writes back
- memwb_rd  in  REGW  MEM/WB destination
- memwb_result  in  XLEN  MEM/WB writeback value
- load_use_hold  out  1  decode and fetch must hold this cycle
- ex_valid  out  1  EX slot valid
- ex_pc  out  XLEN  registered PC
- ex_rd  out  REGW  registered destination
- ex_opcode / ex_funct3 / ex_funct7  out  7/3/7  to ALU opcode/funct3/funct7
- alu_in1 / alu_in2  out  XLEN  to ALU input_one/input_two
- ex_store_data  out  XLEN  forwarded rs2 for stores
- ex_reg_write / ex_mem_read / ex_mem_write  out  1  registered control

Behaviour:
- Reset (reset_n low, asynchronous, immediate):
  - All registered fields clear to 0: ex_valid=0, opcode=7'b0000000, rd=0, all control bits 0.
  - alu_in1, alu_in2 and ex_store_data read 0.
- Register update on rising clk edge, priority high to low:
  - flush: load a bubble.
  - stall: hold every register unchanged.
  - load_use_hold: load a bubble.
  - otherwise: capture all id_* fields (ex_valid <= id_valid).
- Bubble contents: valid=0, reg_write/mem_read/mem_write=0, opcode=0, rd=0. Other data fields are don't-care, but driven as 0.
- Flush wins over stall in the same cycle. A flushed slot never reappears after the stall releases.
- Forwarding is combinational from the registered rs1/rs2 indices (ex_rs1/ex_rs2, internal):
  - Select exmem_result if exmem_reg_write, exmem_rd!=0 and exmem_rd==ex_rsN.
  - Else select memwb_result if memwb_reg_write, memwb_rd!=0 and memwb_rd==ex_rsN.
  - Else select the registered register file data.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Operand select by ex_opcode:
  - 0110011 (R-type) and 1100011 (branch): in1=fwd_rs1, in2=fwd_rs2.
  - 0010011 (I-ALU), 0000011 (load), 0100011 (store), 1100111 (JALR): in1=fwd_rs1, in2=imm.
  - 1101111 (JAL): in1=ex_pc, in2=imm.
  - Any other opcode: in1=0, in2=0.
- ex_store_data always equals fwd_rs2.
- Shift immediates are passed unmodified. The ALU consumes imm[4:0] and funct7.
- load_use_hold is combinational and asserts when all of the following hold:
  - ex_valid and ex_mem_read, with ex_rd!=0.
  - id_valid.
  - Either id_rs1==ex_rd with the ID opcode not JAL, or id_rs2==ex_rd with the ID opcode R-type, store or branch.
- load_use_hold is masked to 0 while flush=1.
- A load-use bubble lasts exactly 1 cycle. The load then advances, clearing the hazard, and the dependent instruction is captured next cycle with MEM/WB forwarding.
- Latency: 1 cycle from ID capture to EX outputs. Forwarded operands are valid in the same cycle as the forwarding inputs.

Test Plan:
- Reset and async assert: assert reset_n low mid-cycle with ex_valid=1 -> ex_valid=0, opcode=0 and alu_in1/alu_in2=0 immediately, with no clock edge.
- Basic R-type: ADD, rs1=x1 (5), rs2=x2 (7), no forwarding -> next cycle alu_in1=5, alu_in2=7, ex_opcode=0110011, ex_valid=1.
- Forwarding priority: EX/MEM rd=x1 result 0x11 and MEM/WB rd=x1 result 0x22 both writing -> alu_in1=0x11. With rd=x0 on both and reg_write set -> alu_in1 equals the register file value.
- Load-use: LW x3 in EX, ADD x4,x3,x5 in ID -> load_use_hold=1 for exactly 1 cycle, then a bubble (ex_valid=0). Next cycle ADD is captured, and alu_in1 = memwb_result forwarded.
- Stall then flush: stall=1 for 3 cycles -> EX outputs unchanged. stall=1 and flush=1 together -> bubble loaded, and ex_valid=0 after stall drops.
- JAL/store operands: JAL pc=0x100, imm=0x20 -> alu_in1=0x100, alu_in2=0x20. SW with EX/MEM forwarding of rs2=0xABCD -> ex_store_data=0xABCD, alu_in2=imm.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand select and forwarding.
//
// Each cycle the decode-stage fields are captured into the EX slot. The slot's
// rs1/rs2 indices are checked against the EX/MEM and MEM/WB destinations to
// forward newer results into the ALU operands and the store data. A load in EX
// whose destination is read by the instruction in ID raises load_use_hold. A
// bubble then replaces that instruction for one cycle.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   id_*                          decoded instruction fields from ID
//   stall                         hold the EX slot unchanged
//   flush                         squash the EX slot (wins over stall)
//   exmem_*, memwb_*              writeback info used for forwarding
//   load_use_hold                 decode and fetch must hold this cycle
//   ex_valid/pc/rd/opcode/funct*  registered slot fields
//   alu_in1, alu_in2              selected, forwarded ALU operands
//   ex_store_data                 forwarded rs2 for stores
//   ex_reg_write/mem_read/write   registered control bits
module id_ex_operand_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_funct3,
    input  logic [6:0]      id_funct7,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            stall,
    input  logic            flush,
    input  logic            exmem_reg_write,
    input  logic [REGW-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [REGW-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic            load_use_hold,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [REGW-1:0] ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [XLEN-1:0] ex_store_data,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write
);

    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIAlu  = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpJal   = 7'b1101111;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } slot_t;

    slot_t slot_q, slot_d, id_slot;
    logic  id_uses_rs1, id_uses_rs2;
    logic  [XLEN-1:0] fwd_rs1, fwd_rs2;

    // Decode-side view of which source registers the ID instruction reads.
    always_comb begin
        id_uses_rs1 = (id_opcode != OpJal);
        id_uses_rs2 = (id_opcode == OpRType) || (id_opcode == OpStore) ||
                      (id_opcode == OpBranch);
    end

    // A load's data is not available for forwarding until it reaches MEM/WB,
    // so a dependent instruction directly behind it must wait one cycle.
    always_comb begin
        load_use_hold = 1'b0;
        if (!flush && slot_q.valid && slot_q.mem_read && (slot_q.rd != '0) && id_valid) begin
            load_use_hold = (id_uses_rs1 && (id_rs1 == slot_q.rd)) ||
                            (id_uses_rs2 && (id_rs2 == slot_q.rd));
        end
    end

    always_comb begin
        id_slot.valid     = id_valid;
        id_slot.pc        = id_pc;
        id_slot.rs1_data  = id_rs1_data;
        id_slot.rs2_data  = id_rs2_data;
        id_slot.imm       = id_imm;
        id_slot.rs1       = id_rs1;
        id_slot.rs2       = id_rs2;
        id_slot.rd        = id_rd;
        id_slot.opcode    = id_opcode;
        id_slot.funct3    = id_funct3;
        id_slot.funct7    = id_funct7;
        id_slot.reg_write = id_reg_write;
        id_slot.mem_read  = id_mem_read;
        id_slot.mem_write = id_mem_write;
    end

    // Flush outranks stall so a squashed slot cannot survive a held pipeline.
    always_comb begin
        slot_d = slot_q;
        if (flush) begin
            slot_d = '0;
        end else if (stall) begin
            slot_d = slot_q;
        end else if (load_use_hold) begin
            slot_d = '0;
        end else begin
            slot_d = id_slot;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    // EX/MEM holds the newer value, so it beats MEM/WB; x0 is never forwarded.
    function automatic logic [XLEN-1:0] forward(
        input logic [REGW-1:0] idx,
        input logic [XLEN-1:0] rf_data,
        input logic            em_we,
        input logic [REGW-1:0] em_rd,
        input logic [XLEN-1:0] em_res,
        input logic            mw_we,
        input logic [REGW-1:0] mw_rd,
        input logic [XLEN-1:0] mw_res
    );
        if (em_we && (em_rd != '0) && (em_rd == idx)) begin
            return em_res;
        end else if (mw_we && (mw_rd != '0) && (mw_rd == idx)) begin
            return mw_res;
        end
        return rf_data;
    endfunction

    always_comb begin
        fwd_rs1 = forward(slot_q.rs1, slot_q.rs1_data, exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result);
        fwd_rs2 = forward(slot_q.rs2, slot_q.rs2_data, exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result);
    end

    always_comb begin
        alu_in1 = '0;
        alu_in2 = '0;
        case (slot_q.opcode)
            OpRType, OpBranch: begin
                alu_in1 = fwd_rs1;
                alu_in2 = fwd_rs2;
            end
            OpIAlu, OpLoad, OpStore, OpJalr: begin
                alu_in1 = fwd_rs1;
                alu_in2 = slot_q.imm;
            end
            OpJal: begin
                alu_in1 = slot_q.pc;
                alu_in2 = slot_q.imm;
            end
            default: begin
                alu_in1 = '0;
                alu_in2 = '0;
            end
        endcase
    end

    assign ex_store_data = fwd_rs2;
    assign ex_valid      = slot_q.valid;
    assign ex_pc         = slot_q.pc;
    assign ex_rd         = slot_q.rd;
    assign ex_opcode     = slot_q.opcode;
    assign ex_funct3     = slot_q.funct3;
    assign ex_funct7     = slot_q.funct7;
    assign ex_reg_write  = slot_q.reg_write;
    assign ex_mem_read   = slot_q.mem_read;
    assign ex_mem_write  = slot_q.mem_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    logic        clk, reset_n, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [6:0]  id_opcode, id_funct7;
    logic [2:0]  id_funct3;
    logic        id_reg_write, id_mem_read, id_mem_write, stall, flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        load_use_hold, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_pc, alu_in1, alu_in2, ex_store_data;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode, ex_funct7;
    logic [2:0]  ex_funct3;

    id_ex_operand_stage #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_opcode(id_opcode),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .stall(stall), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .load_use_hold(load_use_hold), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .ex_store_data(ex_store_data),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instruction occupying the EX slot.
    typedef struct packed {
        logic        v;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        rw, mr, mw;
    } slot_t;

    slot_t m;
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic slot_t id_slot();
        slot_t s;
        s.v = id_valid; s.pc = id_pc; s.d1 = id_rs1_data; s.d2 = id_rs2_data; s.imm = id_imm;
        s.rs1 = id_rs1; s.rs2 = id_rs2; s.rd = id_rd; s.op = id_opcode; s.f3 = id_funct3;
        s.f7 = id_funct7; s.rw = id_reg_write; s.mr = id_mem_read; s.mw = id_mem_write;
        return s;
    endfunction

    // Value of architectural register idx as seen by the EX stage right now.
    function automatic logic [31:0] reg_value(input logic [4:0] idx, input logic [31:0] stale);
        if (idx == 5'd0) return stale;
        if (exmem_reg_write && exmem_rd == idx) return exmem_result;
        if (memwb_reg_write && memwb_rd == idx) return memwb_result;
        return stale;
    endfunction

    function automatic logic exp_hold(input slot_t s);
        logic reads_rs1, reads_rs2;
        if (flush || !id_valid || !s.v || !s.mr || s.rd == 5'd0) return 1'b0;
        reads_rs1 = (id_opcode != OP_JAL);
        reads_rs2 = (id_opcode == OP_R) || (id_opcode == OP_ST) || (id_opcode == OP_BR);
        return (reads_rs1 && id_rs1 == s.rd) || (reads_rs2 && id_rs2 == s.rd);
    endfunction

    function automatic logic [63:0] exp_operands(input slot_t s);
        logic [31:0] a, b;
        a = reg_value(s.rs1, s.d1);
        b = reg_value(s.rs2, s.d2);
        if (s.op == OP_R || s.op == OP_BR) return {a, b};
        if (s.op == OP_I || s.op == OP_LD || s.op == OP_ST || s.op == OP_JALR) return {a, s.imm};
        if (s.op == OP_JAL) return {s.pc, s.imm};
        return 64'd0;
    endfunction

    function automatic slot_t next_slot(input slot_t s);
        if (flush) return '0;
        if (stall) return s;
        if (exp_hold(s)) return '0;
        return id_slot();
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string step);
        logic [63:0] ops;
        #1;
        ops = exp_operands(m);
        chk({step, "/hold"}, 32'(load_use_hold), 32'(exp_hold(m)));
        chk({step, "/valid"}, 32'(ex_valid), 32'(m.v));
        chk({step, "/pc"}, ex_pc, m.pc);
        chk({step, "/rd"}, 32'(ex_rd), 32'(m.rd));
        chk({step, "/op"}, 32'(ex_opcode), 32'(m.op));
        chk({step, "/f3f7"}, 32'({ex_funct3, ex_funct7}), 32'({m.f3, m.f7}));
        chk({step, "/in1"}, alu_in1, ops[63:32]);
        chk({step, "/in2"}, alu_in2, ops[31:0]);
        chk({step, "/store"}, ex_store_data, reg_value(m.rs2, m.d2));
        chk({step, "/ctl"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'({m.rw, m.mr, m.mw}));
    endtask

    task automatic tick();
        slot_t nxt;
        nxt = next_slot(m);
        @(posedge clk);
        #1;
        m = nxt;
    endtask

    task automatic clear_fwd();
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic set_id(input logic [6:0] op, input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                          input logic [31:0] imm, input logic [31:0] pc);
        id_valid = 1; id_opcode = op; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2;
        id_rs2_data = d2; id_rd = rd; id_imm = imm; id_pc = pc;
        id_funct3 = 3'd0; id_funct7 = 7'd0;
        id_reg_write = (op != OP_ST && op != OP_BR);
        id_mem_read = (op == OP_LD); id_mem_write = (op == OP_ST);
    endtask

    logic [6:0] ops_tbl [9];

    initial begin
        ops_tbl = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR, OP_JAL, OP_LUI, 7'h00};
        reset_n = 0; stall = 0; flush = 0;
        set_id(7'd0, 0, 0, 0, 0, 0, 0, 0);
        id_valid = 0;
        clear_fwd();
        m = '0;
        #2;
        check_all("reset");
        #1 reset_n = 1;

        // Basic ADD x3, x1, x2 with no forwarding.
        @(posedge clk); #1;
        set_id(OP_R, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'h0, 32'h40);
        tick();
        id_valid = 0;
        check_all("add");
        chk("add/in1_lit", alu_in1, 32'd5);
        chk("add/in2_lit", alu_in2, 32'd7);
        chk("add/valid_lit", 32'(ex_valid), 32'd1);

        // Forwarding priority, EX/MEM over MEM/WB.
        exmem_reg_write = 1; exmem_rd = 5'd1; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 5'd1; memwb_result = 32'h22;
        check_all("fwd_both");
        chk("fwd_both/in1_lit", alu_in1, 32'h11);
        exmem_rd = 5'd0;
        check_all("fwd_wb");
        chk("fwd_wb/in1_lit", alu_in1, 32'h22);

        // Async reset mid-cycle with a valid slot.
        clear_fwd();
        reset_n = 0;
        m = '0;
        check_all("async_rst");
        chk("async_rst/valid_lit", 32'(ex_valid), 32'd0);
        chk("async_rst/in1_lit", alu_in1, 32'd0);
        reset_n = 1;

        // x0 destinations are never forwarded.
        set_id(OP_R, 5'd0, 32'h55, 5'd0, 32'h66, 5'd3, 32'h0, 32'h44);
        tick();
        exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'h22;
        check_all("x0");
        chk("x0/in1_lit", alu_in1, 32'h55);
        clear_fwd();

        // Load-use: LW x3 then ADD x4, x3, x5.
        set_id(OP_LD, 5'd1, 32'h100, 5'd0, 32'h0, 5'd3, 32'h8, 32'h48);
        tick();
        set_id(OP_R, 5'd3, 32'h0, 5'd5, 32'h9, 5'd4, 32'h0, 32'h4c);
        check_all("lu_hold");
        chk("lu_hold/lit", 32'(load_use_hold), 32'd1);
        tick();
        check_all("lu_bubble");
        chk("lu_bubble/valid_lit", 32'(ex_valid), 32'd0);
        chk("lu_bubble/hold_lit", 32'(load_use_hold), 32'd0);
        tick();
        memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'hDEAD;
        check_all("lu_fwd");
        chk("lu_fwd/in1_lit", alu_in1, 32'hDEAD);
        clear_fwd();

        // Stall holds the slot, then stall+flush squashes it.
        set_id(OP_I, 5'd2, 32'h40, 5'd0, 32'h0, 5'd7, 32'h4, 32'h50);
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(OP_R, 5'd9, 32'h1, 5'd10, 32'h2, 5'd11, 32'h0, 32'h60 + 32'(i));
            tick();
            check_all("stall");
            chk("stall/in2_lit", alu_in2, 32'h4);
        end
        flush = 1;
        tick();
        check_all("stall_flush");
        chk("stall_flush/valid_lit", 32'(ex_valid), 32'd0);
        flush = 0; stall = 0; id_valid = 0;
        check_all("after_flush");
        chk("after_flush/valid_lit", 32'(ex_valid), 32'd0);

        // JAL operands.
        set_id(OP_JAL, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 32'h20, 32'h100);
        tick();
        check_all("jal");
        chk("jal/in1_lit", alu_in1, 32'h100);
        chk("jal/in2_lit", alu_in2, 32'h20);

        // SW with rs2 forwarded from EX/MEM.
        set_id(OP_ST, 5'd2, 32'h200, 5'd6, 32'h1, 5'd0, 32'h8, 32'h104);
        tick();
        exmem_reg_write = 1; exmem_rd = 5'd6; exmem_result = 32'hABCD;
        check_all("sw");
        chk("sw/store_lit", ex_store_data, 32'hABCD);
        chk("sw/in2_lit", alu_in2, 32'h8);
        clear_fwd();

        // Randomised traffic with dense register collisions.
        for (int i = 0; i < 600; i++) begin
            set_id(ops_tbl[$urandom_range(0, 8)], 5'($urandom_range(0, 7)), $urandom,
                   5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
                   $urandom);
            id_valid = ($urandom_range(0, 5) != 0);
            id_funct3 = 3'($urandom); id_funct7 = 7'($urandom);
            id_reg_write = 1'($urandom);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7));
            exmem_result = $urandom;
            memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7));
            memwb_result = $urandom;
            check_all("rnd");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
